// File: rtl/perm_pkg.sv
// -----------------------------------------------------------------------------
// perm_pkg
// Shared constants and types for the permutation-generator output lanes.
//   BOT_WIDTH            width of one permuted bot
//   PERMS_67 / PERMS_7   words per series for the 6/7 and 7-only generators
//   GEN_REQUEST_LATENCY  cycles between a generator request and its first word
//   fifo_word_t          one buffered entry: series-last flag plus bot
// -----------------------------------------------------------------------------
package perm_pkg;

  localparam int BOT_WIDTH           = 128;
  localparam int PERMS_67            = 42;
  localparam int PERMS_7             = 7;
  localparam int GEN_REQUEST_LATENCY = 4;

  typedef struct packed {
    logic                 last;
    logic [BOT_WIDTH-1:0] bot;
  } fifo_word_t;

  // Smallest almost-full margin that still absorbs one whole series in flight:
  // the generator only honours slowDown between series.
  function automatic int min_margin(input int perms_per_bot);
    return perms_per_bot + GEN_REQUEST_LATENCY + 2;
  endfunction

endpackage

// File: rtl/fwft_sync_fifo.sv
// -----------------------------------------------------------------------------
// fwft_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// pop_data whenever empty is low; pop consumes it.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data; accepted when not full or when a pop happens
//                in the same cycle, otherwise ignored
//   pop          consume the head entry; ignored when empty
//   pop_data     head entry (valid while !empty)
//   count        number of stored entries (0 .. 2**DEPTH_LOG2)
//   full, empty  status derived from count
// -----------------------------------------------------------------------------
module fwft_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_COUNT = {1'b1, {PW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A full FIFO can still take a word if the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/permutation_stream_receiver.sv
// -----------------------------------------------------------------------------
// permutation_stream_receiver
// Receiving end of one permutator output lane. Incoming bots pass through a
// one-word pending register (so the series-finished flag, which arrives one
// cycle after the last word, can be attached to it) and then a FWFT FIFO that
// is offered downstream with a valid/ready handshake. Series lengths are
// checked and a registered slowDown throttles the generator.
//   clk, rst_n            clock, asynchronous active-low reset
//   botIn / botInValid    permuted bot and its valid
//   botSeriesFinishedIn   previous series complete (with next series' first
//                         word, or on an idle cycle)
//   slowDown              registered almost-full backpressure
//   dataOut / dataOutLast / dataOutValid / readReady   downstream handshake
//   seriesCount           completed series, wraps at 2**32
//   errorSeriesLength     sticky: some series length != PERMS_PER_BOT
//   overflow              sticky: a word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module permutation_stream_receiver
  import perm_pkg::*;
#(
  parameter int PERMS_PER_BOT      = PERMS_67,
  parameter int DEPTH_LOG2         = 6,
  // Must be at least PERMS_PER_BOT + GEN_REQUEST_LATENCY + 2 (see min_margin).
  parameter int ALMOST_FULL_MARGIN = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BOT_WIDTH-1:0] botIn,
  input  logic                 botInValid,
  input  logic                 botSeriesFinishedIn,
  output logic                 slowDown,
  output logic [BOT_WIDTH-1:0] dataOut,
  output logic                 dataOutLast,
  output logic                 dataOutValid,
  input  logic                 readReady,
  output logic [31:0]          seriesCount,
  output logic                 errorSeriesLength,
  output logic                 overflow
);

  localparam int CW       = DEPTH_LOG2 + 1;
  localparam int OW       = DEPTH_LOG2 + 2;
  localparam int SLOW_RAW = (1 << DEPTH_LOG2) - ALMOST_FULL_MARGIN;
  localparam logic [OW-1:0] SLOW_THRESH   = (SLOW_RAW < 0) ? '0 : OW'(SLOW_RAW);
  localparam logic [31:0]   PERMS_EXPECTED = 32'(PERMS_PER_BOT);

  logic                 pend_valid_q, pend_valid_d;
  logic [BOT_WIDTH-1:0] pend_bot_q, pend_bot_d;
  logic [7:0]           series_len_q, series_len_d;
  logic [31:0]          series_count_q, series_count_d;
  logic                 err_len_q, err_len_d;
  logic                 overflow_q, overflow_d;
  logic                 slow_q, slow_d;

  fifo_word_t           push_word, head_word;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count, fifo_count_next;
  logic                 push_ok;
  logic [OW-1:0]        occ_next;

  fwft_sync_fifo #(
    .WIDTH      ($bits(fifo_word_t)),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (head_word),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    pend_valid_d   = pend_valid_q;
    pend_bot_d     = pend_bot_q;
    series_len_d   = series_len_q;
    series_count_d = series_count_q;
    err_len_d      = err_len_q;
    overflow_d     = overflow_q;

    // The pending word leaves as soon as we learn whether it closes its
    // series: a new valid word says "only if finished is set", an idle
    // finished cycle says "yes".
    fifo_pop       = readReady && !fifo_empty;
    fifo_push      = pend_valid_q && (botInValid || botSeriesFinishedIn);
    push_word.bot  = pend_bot_q;
    push_word.last = botInValid ? botSeriesFinishedIn : 1'b1;
    push_ok        = fifo_push && (!fifo_full || fifo_pop);
    if (fifo_push && !push_ok) overflow_d = 1'b1;

    if (botInValid) begin
      pend_valid_d = 1'b1;
      pend_bot_d   = botIn;
    end else if (botSeriesFinishedIn) begin
      pend_valid_d = 1'b0;
    end

    // Finished closes the running series; a word arriving with it is the
    // first word of the next one.
    if (botSeriesFinishedIn) begin
      if (32'(series_len_q) != PERMS_EXPECTED) err_len_d = 1'b1;
      series_count_d = series_count_q + 32'd1;
      series_len_d   = {7'd0, botInValid};
    end else if (botInValid && series_len_q != 8'hFF) begin
      series_len_d = series_len_q + 8'd1;
    end

    // Threshold on next-state occupancy so slowDown is fresh right after the edge.
    fifo_count_next = fifo_count + CW'(push_ok) - CW'(fifo_pop);
    occ_next        = {1'b0, fifo_count_next} + OW'(pend_valid_d);
    slow_d          = (occ_next >= SLOW_THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q   <= 1'b0;
      series_len_q   <= '0;
      series_count_q <= '0;
      err_len_q      <= 1'b0;
      overflow_q     <= 1'b0;
      slow_q         <= 1'b0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      series_len_q   <= series_len_d;
      series_count_q <= series_count_d;
      err_len_q      <= err_len_d;
      overflow_q     <= overflow_d;
      slow_q         <= slow_d;
    end
  end

  // Pending data is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_bot_q <= pend_bot_d;
  end

  assign slowDown          = slow_q;
  assign dataOutValid      = !fifo_empty;
  assign dataOut           = fifo_empty ? '0 : head_word.bot;
  assign dataOutLast       = !fifo_empty && head_word.last;
  assign seriesCount       = series_count_q;
  assign errorSeriesLength = err_len_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_permutation_stream_receiver.sv
// -----------------------------------------------------------------------------
// tb_permutation_stream_receiver
// Directed bench for permutation_stream_receiver with a queue-based reference
// model compared on every falling edge, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_permutation_stream_receiver;

  localparam int PERMS  = 42;
  localparam int DL2    = 6;
  localparam int MARGIN = 48;
  localparam int DEPTH  = 1 << DL2;
  localparam int THRESH = DEPTH - MARGIN;

  logic         clk;
  logic         rst_n;
  logic [127:0] botIn;
  logic         botInValid;
  logic         botSeriesFinishedIn;
  logic         slowDown;
  logic [127:0] dataOut;
  logic         dataOutLast;
  logic         dataOutValid;
  logic         readReady;
  logic [31:0]  seriesCount;
  logic         errorSeriesLength;
  logic         overflow;

  permutation_stream_receiver #(
    .PERMS_PER_BOT      (PERMS),
    .DEPTH_LOG2         (DL2),
    .ALMOST_FULL_MARGIN (MARGIN)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .botIn               (botIn),
    .botInValid          (botInValid),
    .botSeriesFinishedIn (botSeriesFinishedIn),
    .slowDown            (slowDown),
    .dataOut             (dataOut),
    .dataOutLast         (dataOutLast),
    .dataOutValid        (dataOutValid),
    .readReady           (readReady),
    .seriesCount         (seriesCount),
    .errorSeriesLength   (errorSeriesLength),
    .overflow            (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: pending word, FIFO as a queue of {last, bot}.
  bit           m_pv;
  logic [127:0] m_pb;
  logic [128:0] m_q[$];
  int           m_len;
  int unsigned  m_series;
  bit           m_err, m_ovf, m_slow;

  // Words the DUT handed downstream, in order.
  logic [127:0] log_data[$];
  bit           log_last[$];

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pv = 1'b0; m_pb = '0; m_q.delete();
    m_len = 0; m_series = 0;
    m_err = 1'b0; m_ovf = 1'b0; m_slow = 1'b0;
  endtask

  // One clock edge of the lane as described: the consumer takes the head if
  // ready, the pending word goes downstream once its last flag is known, and
  // a finished pulse closes the running series.
  task automatic model_step(input bit v, input bit f, input logic [127:0] b, input bit r);
    bit popped;
    popped = r && (m_q.size() > 0);
    if (popped) void'(m_q.pop_front());
    if (m_pv && (v || f)) begin
      if (m_q.size() < DEPTH) m_q.push_back({(v ? f : 1'b1), m_pb});
      else                    m_ovf = 1'b1;
    end
    if (v) begin
      m_pv = 1'b1; m_pb = b;
    end else if (f) begin
      m_pv = 1'b0;
    end
    if (f) begin
      if (m_len != PERMS) m_err = 1'b1;
      m_series = m_series + 1;
      m_len = v ? 1 : 0;
    end else if (v && m_len < 255) begin
      m_len++;
    end
    m_slow = (m_q.size() + (m_pv ? 1 : 0)) >= THRESH;
  endtask

  // Single compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", dataOutValid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        check("data", dataOut, m_q[0][127:0]);
        check("last", dataOutLast, m_q[0][128]);
      end
      check("series_count", seriesCount, m_series);
      check("err_len", errorSeriesLength, m_err);
      check("overflow", overflow, m_ovf);
      check("slow_down", slowDown, m_slow);
      if (dataOutValid && readReady) begin
        log_data.push_back(dataOut);
        log_last.push_back(dataOutLast);
      end
    end
  end

  task automatic cyc(input bit v, input bit f, input logic [127:0] b, input bit r);
    botInValid = v; botSeriesFinishedIn = f; botIn = b; readReady = r;
    @(posedge clk);
    model_step(v, f, b, r);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, r);
  endtask

  task automatic feed(input int first, input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 128'(first + i), r);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_slow"},  slowDown, 0);
    check({tag, "_valid"}, dataOutValid, 0);
    check({tag, "_last"},  dataOutLast, 0);
    check({tag, "_count"}, seriesCount, 0);
    check({tag, "_err"},   errorSeriesLength, 0);
    check({tag, "_ovf"},   overflow, 0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_reset();
    log_data.delete(); log_last.delete();
    chk_en = 1'b1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    botInValid = 1'b0; botSeriesFinishedIn = 1'b0; botIn = '0; readReady = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    release_reset();
  endtask

  task automatic check_log(input string tag, input int first, input int n, input int last_val);
    check({tag, "_n"}, log_data.size(), n);
    for (int i = 0; i < n && i < log_data.size(); i++) begin
      check({tag, "_data"}, log_data[i], first + i);
      check({tag, "_last"}, log_last[i], (first + i) == last_val);
    end
    log_data.delete(); log_last.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    botIn = '0; botInValid = 1'b0; botSeriesFinishedIn = 1'b0; readReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    release_reset();

    // Normal series 1..42, closed by word 43 arriving with finished.
    feed(1, 42, 1'b1);
    cyc(1'b1, 1'b1, 128'd43, 1'b1);
    idle(3, 1'b1);
    check_log("normal", 1, 42, 42);
    check("normal_series", seriesCount, 1);
    check("normal_err", errorSeriesLength, 0);

    // End of stream: 43..84 then finished on an idle cycle.
    feed(44, 41, 1'b1);
    cyc(1'b0, 1'b1, '0, 1'b1);
    idle(3, 1'b1);
    check_log("eos", 43, 42, 84);
    check("eos_series", seriesCount, 2);
    check("eos_err", errorSeriesLength, 0);
    check("eos_empty", dataOutValid, 0);
    // Second finished with nothing pending: a zero-length series.
    cyc(1'b0, 1'b1, '0, 1'b1);
    check("eos2_err", errorSeriesLength, 1);
    check("eos2_series", seriesCount, 3);

    // Short series of 41, then a correct one: the error stays set.
    do_reset();
    feed(1, 41, 1'b1);
    cyc(1'b0, 1'b1, '0, 1'b1);
    check("short_err", errorSeriesLength, 1);
    check("short_series", seriesCount, 1);
    feed(100, 42, 1'b1);
    cyc(1'b0, 1'b1, '0, 1'b1);
    idle(2, 1'b1);
    check("short_sticky", errorSeriesLength, 1);
    check("short_series2", seriesCount, 2);

    // Backpressure threshold at occupancy 16.
    do_reset();
    feed(1, 15, 1'b0);
    check("bp_below", slowDown, 0);
    feed(16, 1, 1'b0);
    check("bp_rise", slowDown, 1);
    idle(1, 1'b1);
    check("bp_fall", slowDown, 0);

    // Full FIFO with simultaneous push and pop: no loss, order kept.
    do_reset();
    feed(1, 65, 1'b0);
    check("pp_full_valid", dataOutValid, 1);
    check("pp_full_head", dataOut, 1);
    feed(66, 10, 1'b1);
    check("pp_ovf", overflow, 0);
    idle(70, 1'b1);
    check_log("pp", 1, 74, 0);

    // Overflow: the 65th push into a full FIFO is dropped.
    do_reset();
    feed(1, 65, 1'b0);
    check("ovf_before", overflow, 0);
    feed(66, 1, 1'b0);
    check("ovf_set", overflow, 1);
    idle(70, 1'b1);
    check_log("ovf", 1, 64, 0);
    check("ovf_sticky", overflow, 1);

    // Asynchronous reset in the middle of a series.
    feed(200, 20, 1'b0);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_outputs_zero("midrst");
    botInValid = 1'b0; botSeriesFinishedIn = 1'b0; readReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    release_reset();
    feed(1, 42, 1'b1);
    cyc(1'b0, 1'b1, '0, 1'b1);
    idle(3, 1'b1);
    check_log("fresh", 1, 42, 42);
    check("fresh_err", errorSeriesLength, 0);
    check("fresh_series", seriesCount, 1);
    check("fresh_ovf", overflow, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
